// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: single-outstanding I-cache reads feeding a DEPTH-entry
// {pc, instr} prefetch FIFO, with redirect flushing both the queue and the in-flight fetch.
module fetch_prefetch_queue #(
    parameter int unsigned      WIDTH    = 16,
    parameter int unsigned      DEPTH    = 4,
    parameter int unsigned      PC_STEP  = 2,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   icache_read,
    output logic [WIDTH-1:0]       icache_addr,
    input  logic                   icache_resp,
    input  logic [WIDTH-1:0]       icache_rdata,
    input  logic                   redirect,
    input  logic [WIDTH-1:0]       redirect_pc,
    input  logic                   id_ready,
    output logic                   id_valid,
    output logic [WIDTH-1:0]       id_instr,
    output logic [WIDTH-1:0]       id_pc,
    output logic                   inject_nop,
    output logic [$clog2(DEPTH):0] q_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] fetch_pc_q;
    logic [WIDTH-1:0] drop_addr_q;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] instr_mem [DEPTH];
    logic [WIDTH-1:0] pc_mem    [DEPTH];
    logic             push;
    logic             pop;
    logic             room;

    // Redirect overrides both push and pop so a flush cycle never touches storage.
    assign push = (state_q == REQ) && icache_resp && !redirect;
    assign pop  = id_valid && id_ready && !redirect;
    assign room = (count_d < CW'(DEPTH));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            drop_addr_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (redirect) begin
                        fetch_pc_q <= redirect_pc;
                        state_q    <= REQ;
                    end else if (room) begin
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (icache_resp) begin
                        if (redirect) begin
                            fetch_pc_q <= redirect_pc;
                        end else begin
                            fetch_pc_q <= fetch_pc_q + WIDTH'(PC_STEP);
                            state_q    <= room ? REQ : IDLE;
                        end
                    end else if (redirect) begin
                        // Keep the outstanding address on the bus until its response drains.
                        drop_addr_q <= fetch_pc_q;
                        fetch_pc_q  <= redirect_pc;
                        state_q     <= DROP;
                    end
                end
                DROP: begin
                    if (redirect)    fetch_pc_q <= redirect_pc;
                    if (icache_resp) state_q    <= REQ;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                instr_mem[i] <= '0;
                pc_mem[i]    <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) begin
                instr_mem[wr_ptr_q] <= icache_rdata;
                pc_mem[wr_ptr_q]    <= fetch_pc_q;
            end
        end
    end

    assign icache_read = (state_q != IDLE);
    assign icache_addr = (state_q == DROP) ? drop_addr_q : fetch_pc_q;
    assign id_valid    = (count_q != '0);
    assign id_instr    = instr_mem[rd_ptr_q];
    assign id_pc       = pc_mem[rd_ptr_q];
    assign inject_nop  = ~id_valid;
    assign q_count     = count_q;

endmodule
